// File: rtl/udc_pkg.sv
// udc_pkg: register map, CTRL/STATUS bit positions and FSM states for udc_counter
package udc_pkg;
  localparam logic [1:0] UDC_ADDR_LOAD   = 2'd0;
  localparam logic [1:0] UDC_ADDR_CTRL   = 2'd1;
  localparam logic [1:0] UDC_ADDR_LIMIT  = 2'd2;
  localparam logic [1:0] UDC_ADDR_STATUS = 2'd3;
  localparam int CTRL_DIR     = 0;
  localparam int CTRL_WRAP    = 1;
  localparam int CTRL_STOP    = 2;
  localparam int CTRL_PSC_LSB = 4;
  localparam int STAT_RUN = 0;
  localparam int STAT_EC  = 1;
  localparam int STAT_ERR = 2;
  localparam int STAT_DIR = 3;
  typedef enum logic [1:0] {IDLE, RUN, DONE} udc_state_e;
endpackage

// File: rtl/udc_bus_if.sv
// udc_bus_if: write-strobe edge detect, address decode, read mux, tri-state data drive, bus conflict detect
module udc_bus_if import udc_pkg::*; (
  input  logic       clk,
  input  logic       reset_i,
  inout  wire  [7:0] io_data,
  input  logic [1:0] i_addr,
  input  logic       i_ncs,
  input  logic       i_nwr,
  input  logic       i_nrd,
  input  logic [7:0] i_load_rd,
  input  logic [7:0] i_ctrl_rd,
  input  logic [7:0] i_limit_rd,
  input  logic [7:0] i_status_rd,
  output logic [3:0] o_wr_sel,
  output logic [7:0] o_wdata,
  output logic       o_conflict
);
  logic       r_nwr;
  logic       w_wr;
  logic       w_rd;
  logic [7:0] w_rdata;
  always_ff @(posedge clk) r_nwr <= reset_i ? 1'b1 : i_nwr;
  // a held-low strobe only writes once, on its falling edge
  assign w_wr       = !i_ncs && !i_nwr && i_nrd && r_nwr;
  assign w_rd       = !i_ncs && !i_nrd && i_nwr;
  assign o_conflict = !i_ncs && !i_nwr && !i_nrd;
  assign o_wr_sel   = w_wr ? 4'b0001 << i_addr : 4'b0000;
  assign o_wdata    = io_data;
  assign w_rdata    = i_addr == UDC_ADDR_LOAD  ? i_load_rd  :
                      i_addr == UDC_ADDR_CTRL  ? i_ctrl_rd  :
                      i_addr == UDC_ADDR_LIMIT ? i_limit_rd : i_status_rd;
  assign io_data    = w_rd ? w_rdata : 8'hzz;
endmodule

// File: rtl/udc_counter.sv
// udc_counter: loadable up/down counter behind the UDC register bus.
// Define UDC_PRESCALE_EN to make CTRL[7:4] divide the count tick by CTRL[7:4]+1.
module udc_counter import udc_pkg::*; #(
  parameter int         PRESCALE_W = 4,
  parameter logic [7:0] LIMIT_RST  = 8'hFF
) (
  input  logic       clk,
  input  logic       reset_i,
  inout  wire  [7:0] d_in,
  input  logic       A1_i,
  input  logic       A0_i,
  input  logic       ncs,
  input  logic       nwr,
  input  logic       nrd,
  input  logic       start_i,
  output logic [7:0] c_out,
  output logic       dir_o,
  output logic       err_o,
  output logic       ec_o
);
`ifdef UDC_PRESCALE_EN
  localparam logic [7:0] CTRL_WMASK = 8'hF3;
`else
  localparam logic [7:0] CTRL_WMASK = 8'h03;
`endif
  udc_state_e            r_state;
  udc_state_e            w_state_nx;
  logic [7:0]            r_load;
  logic [7:0]            r_ctrl;
  logic [7:0]            r_limit;
  logic [7:0]            r_cnt;
  logic [7:0]            w_cnt_nx;
  logic [7:0]            w_load_nx;
  logic [7:0]            w_status;
  logic [7:0]            w_wdata;
  logic [3:0]            w_wr_sel;
  logic [PRESCALE_W-1:0] r_pcnt;
  logic                  r_ec;
  logic                  r_ec_st;
  logic                  r_err;
  logic                  w_ec_nx;
  logic                  w_conflict;
  logic                  w_run;
  logic                  w_stop;
  logic                  w_start_ok;
  logic                  w_tick;
  logic                  w_err;
  logic                  w_ec_clr;
  logic                  w_err_clr;

  udc_bus_if u_bus (
    .clk         (clk),
    .reset_i     (reset_i),
    .io_data     (d_in),
    .i_addr      ({A1_i, A0_i}),
    .i_ncs       (ncs),
    .i_nwr       (nwr),
    .i_nrd       (nrd),
    .i_load_rd   (r_cnt),
    .i_ctrl_rd   (r_ctrl),
    .i_limit_rd  (r_limit),
    .i_status_rd (w_status),
    .o_wr_sel    (w_wr_sel),
    .o_wdata     (w_wdata),
    .o_conflict  (w_conflict)
  );

  assign w_run      = r_state == RUN;
  assign w_stop     = w_wr_sel[UDC_ADDR_CTRL] && w_wdata[CTRL_STOP];
  assign w_start_ok = start_i && !w_run;
  assign w_err      = w_conflict || (w_wr_sel[UDC_ADDR_LOAD] && w_run) || (start_i && w_run);
  assign w_load_nx  = (w_wr_sel[UDC_ADDR_LOAD] && !w_run) ? w_wdata : r_load;
  assign w_ec_clr   = w_wr_sel[UDC_ADDR_STATUS] && w_wdata[STAT_EC];
  assign w_err_clr  = w_wr_sel[UDC_ADDR_STATUS] && w_wdata[STAT_ERR];
  // with the prescale field masked to zero this ticks every clock
  assign w_tick     = r_pcnt == PRESCALE_W'(r_ctrl[7:CTRL_PSC_LSB]);

  always_comb begin
    w_status           = 8'h00;
    w_status[STAT_RUN] = w_run;
    w_status[STAT_EC]  = r_ec_st;
    w_status[STAT_ERR] = r_err;
    w_status[STAT_DIR] = r_ctrl[CTRL_DIR];
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_ec_nx    = 1'b0;
    if (r_state == IDLE) begin
      w_cnt_nx   = w_load_nx;
      w_state_nx = start_i ? RUN : IDLE;
    end else if (w_stop) begin
      w_state_nx = IDLE;
      w_cnt_nx   = w_load_nx;
    end else if (r_state == DONE) begin
      w_state_nx = start_i ? RUN : DONE;
      w_cnt_nx   = start_i ? w_load_nx : r_cnt;
    end else if (w_tick) begin
      if (r_cnt == (r_ctrl[CTRL_DIR] ? 8'h00 : r_limit)) begin
        w_ec_nx    = 1'b1;
        w_cnt_nx   = r_ctrl[CTRL_WRAP] ? r_load : r_cnt;
        w_state_nx = r_ctrl[CTRL_WRAP] ? RUN : DONE;
      end else begin
        w_cnt_nx = r_ctrl[CTRL_DIR] ? r_cnt - 8'd1 : r_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_cnt   <= 8'h00;
      r_load  <= 8'h00;
      r_ctrl  <= 8'h00;
      r_limit <= LIMIT_RST;
      r_pcnt  <= '0;
      r_ec    <= 1'b0;
      r_ec_st <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_load  <= w_load_nx;
      r_ec    <= w_ec_nx;
      r_ec_st <= w_ec_nx || (r_ec_st && !w_ec_clr);
      r_err   <= w_err || (r_err && !w_err_clr);
      r_pcnt  <= (w_wr_sel[UDC_ADDR_CTRL] || w_start_ok || w_tick) ? '0 : r_pcnt + 1'b1;
      if (w_wr_sel[UDC_ADDR_CTRL])
        r_ctrl <= w_wdata & CTRL_WMASK;
      if (w_wr_sel[UDC_ADDR_LIMIT])
        r_limit <= w_wdata;
    end
  end

  assign c_out = r_cnt;
  assign dir_o = r_ctrl[CTRL_DIR];
  assign err_o = r_err;
  assign ec_o  = r_ec;
endmodule

// File: tb/tb_udc_counter.sv
// tb_udc_counter: directed and random bus traffic checked against a behavioural model of the counter
module tb_udc_counter;
`ifdef UDC_PRESCALE_EN
  localparam int PSC_DIV = 3;
  localparam int CTRL20_RD = 8'h20;
`else
  localparam int PSC_DIV = 1;
  localparam int CTRL20_RD = 8'h00;
`endif
  logic       clk = 0;
  logic       reset_i = 0;
  logic       A1_i = 0;
  logic       A0_i = 0;
  logic       ncs = 1;
  logic       nwr = 1;
  logic       nrd = 1;
  logic       start_i = 0;
  logic       tb_drv = 0;
  logic [7:0] tb_wd = 0;
  wire  [7:0] d_in;
  logic [7:0] c_out;
  logic       dir_o;
  logic       err_o;
  logic       ec_o;
  int n_chk = 0;
  int n_fail = 0;
  // model: mode 0 idle, 1 counting, 2 finished
  int m_mode, m_load, m_limit, m_cnt, m_dir, m_wrap, m_psc, m_pcnt, m_ec, m_ecs, m_err, m_pnwr;

  always #5 clk = ~clk;
  assign d_in = tb_drv ? tb_wd : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pd
    pulldown (d_in[g]);
  end

  udc_counter dut (
    .clk     (clk),
    .reset_i (reset_i),
    .d_in    (d_in),
    .A1_i    (A1_i),
    .A0_i    (A0_i),
    .ncs     (ncs),
    .nwr     (nwr),
    .nrd     (nrd),
    .start_i (start_i),
    .c_out   (c_out),
    .dir_o   (dir_o),
    .err_o   (err_o),
    .ec_o    (ec_o)
  );

  task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_read(int a);
    case (a)
      0: return 8'(m_cnt);
      1: return 8'(m_psc << 4 | m_wrap << 1 | m_dir);
      2: return 8'(m_limit);
      default: return 8'(m_dir << 3 | m_err << 2 | m_ecs << 1 | int'(m_mode == 1));
    endcase
  endfunction

  task automatic cyc();
    int a, run, wr, stop, err, tick, n_load, n_mode, n_cnt, n_ec;
    #1;
    a = {30'd0, A1_i, A0_i};
    if (!ncs && !nrd && nwr) check("rd", d_in, m_read(a));
    else if (!tb_drv) check("hiz", d_in, 8'h00);
    @(posedge clk);
    if (reset_i) begin
      m_mode = 0; m_load = 0; m_limit = 255; m_cnt = 0; m_dir = 0; m_wrap = 0; m_psc = 0;
      m_pcnt = 0; m_ec = 0; m_ecs = 0; m_err = 0; m_pnwr = 1;
    end else begin
      run  = int'(m_mode == 1);
      wr   = int'(!ncs && !nwr && nrd && m_pnwr != 0);
      stop = int'(wr != 0 && a == 1 && tb_wd[2]);
      err  = int'((!ncs && !nwr && !nrd) || (wr != 0 && a == 0 && run != 0) || (start_i && run != 0));
      n_load = (wr != 0 && a == 0 && run == 0) ? int'(tb_wd) : m_load;
      tick = int'(m_pcnt == m_psc);
      n_mode = m_mode; n_cnt = m_cnt; n_ec = 0;
      if (m_mode == 0) begin
        n_cnt = n_load;
        if (start_i) n_mode = 1;
      end else if (stop != 0) begin
        n_mode = 0; n_cnt = n_load;
      end else if (m_mode == 2) begin
        if (start_i) begin n_mode = 1; n_cnt = n_load; end
      end else if (tick != 0) begin
        if (m_cnt == (m_dir != 0 ? 0 : m_limit)) begin
          n_ec = 1;
          if (m_wrap != 0) n_cnt = n_load; else n_mode = 2;
        end else n_cnt = (m_cnt + (m_dir != 0 ? 255 : 1)) % 256;
      end
      m_pcnt = ((wr != 0 && a == 1) || (start_i && run == 0) || tick != 0) ? 0 : (m_pcnt + 1) % 16;
      m_ecs  = int'(n_ec != 0 || (m_ecs != 0 && !(wr != 0 && a == 3 && tb_wd[1])));
      m_err  = int'(err != 0 || (m_err != 0 && !(wr != 0 && a == 3 && tb_wd[2])));
      if (wr != 0 && a == 1) begin
        m_dir = int'(tb_wd[0]); m_wrap = int'(tb_wd[1]);
`ifdef UDC_PRESCALE_EN
        m_psc = int'(tb_wd[7:4]);
`endif
      end
      if (wr != 0 && a == 2) m_limit = int'(tb_wd);
      m_load = n_load; m_mode = n_mode; m_cnt = n_cnt; m_ec = n_ec; m_pnwr = int'(nwr);
    end
    #1;
    check("c_out", c_out, 8'(m_cnt));
    check("dir_o", 8'(dir_o), 8'(m_dir));
    check("err_o", 8'(err_o), 8'(m_err));
    check("ec_o", 8'(ec_o), 8'(m_ec));
    @(negedge clk);
  endtask

  task automatic bus(logic cs, logic w, logic r, int a, logic [7:0] d);
    ncs = cs; nwr = w; nrd = r; {A1_i, A0_i} = 2'(a); tb_wd = d; tb_drv = !w;
  endtask

  task automatic wr(int a, logic [7:0] d);
    bus(0, 0, 1, a, d); cyc();
    bus(1, 1, 1, a, 0); cyc();
  endtask

  task automatic rd(int a, string tag, int exp);
    bus(0, 1, 0, a, 0);
    #1 check(tag, d_in, 8'(exp));
    cyc();
    bus(1, 1, 1, a, 0);
  endtask

  task automatic go();
    start_i = 1; cyc(); start_i = 0;
  endtask

  initial begin
    int seq[4] = '{3, 2, 1, 0};
    @(negedge clk);
    bus(1, 1, 1, 2, 0);
    reset_i = 1; cyc(); reset_i = 0;
    check("rst_cout", c_out, 8'h00);
    check("rst_ec", 8'(ec_o), 8'h00);
    rd(2, "limit_rst", 8'hFF);
    bus(1, 1, 1, 2, 0);
    #1 check("hiz_rst", d_in, 8'h00);
    cyc();
    // one-shot up count to LIMIT
    wr(0, 8'h05); wr(2, 8'h08); wr(1, 8'h00);
    go();
    check("up_first", c_out, 8'h05);
    for (int v = 6; v <= 8; v++) begin
      cyc(); check("up_step", c_out, 8'(v));
    end
    cyc(); check("up_ec", 8'(ec_o), 8'h01); check("up_hold", c_out, 8'h08);
    cyc(); check("up_ec_once", 8'(ec_o), 8'h00);
    rd(3, "status_done", 8'h02);
    check("done_hold", c_out, 8'h08);
    // down count with reload
    wr(0, 8'h03); wr(1, 8'h03);
    go();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cyc();
      check("wrap_cnt", c_out, 8'(seq[i % 4]));
      check("wrap_ec", 8'(ec_o), 8'(i > 0 && i % 4 == 0));
    end
    wr(1, 8'h04);
    rd(1, "ctrl_stop_clr", 8'h00);
    // errors
    bus(0, 0, 0, 0, 8'h77); cyc();
    bus(1, 1, 1, 0, 0); cyc();
    check("conflict_err", 8'(err_o), 8'h01);
    rd(0, "conflict_noload", 8'h03);
    wr(3, 8'h04);
    check("err_clr", 8'(err_o), 8'h00);
    go();
    wr(0, 8'h55);
    check("load_run_err", 8'(err_o), 8'h01);
    wr(1, 8'h04);
    check("load_kept", c_out, 8'h03);
    // prescaler
    wr(1, 8'h20);
    rd(1, "ctrl_psc", CTRL20_RD);
    go();
    for (int i = 1; i <= 4; i++) begin
      cyc(); check("psc_step", c_out, 8'(3 + i / PSC_DIV));
    end
    // reset mid-run
    wr(1, 8'h04); wr(1, 8'h00); wr(0, 8'h00);
    go();
    for (int i = 0; i < 20 && c_out != 8'h07; i++) cyc();
    check("reach7", c_out, 8'h07);
    reset_i = 1; cyc(); reset_i = 0;
    check("rst_run_cout", c_out, 8'h00);
    check("rst_run_ec", 8'(ec_o), 8'h00);
    check("rst_run_err", 8'(err_o), 8'h00);
    rd(3, "rst_status", 8'h00);
    // random traffic
    for (int k = 0; k < 800; k++) begin
      int r, a;
      logic [7:0] d;
      r = int'($urandom_range(0, 39));
      a = int'($urandom_range(0, 3));
      d = 8'($urandom_range(0, 15));
      if (a == 1) d = (8'($urandom) & 8'hF3) | ($urandom_range(0, 5) == 0 ? 8'h04 : 8'h00);
      if (r < 20) bus(1, 1, 1, a, 0);
      else if (r < 29) bus(0, 0, 1, a, d);
      else if (r < 33) bus(0, 1, 0, a, 0);
      else if (r < 34) bus(0, 0, 0, a, d);
      else bus(1, 1, 1, a, 0);
      start_i = r >= 34 && r < 38;
      reset_i = r == 38;
      cyc();
    end
    start_i = 0; reset_i = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
